dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 19, the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 10, the data memory address width (1024 words).
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports cpu_req/cpu_we  input  1 each  CPU access request / write-not-read.
REQ-006 The block SHALL have ports cpu_addr  input  ADDR_W  and cpu_wdata  input  WORD_SIZE  CPU address and write data.
REQ-007 The block SHALL have ports cpu_gnt/cpu_rvalid  output  1 each  CPU grant pulse / read-data-valid pulse.
REQ-008 The block SHALL have port cpu_rdata  output  WORD_SIZE  CPU read data.
REQ-009 The block SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, identical to the cpu_* set, for the DMA requester.
REQ-010 The block SHALL have ports mem_wr_en/mem_rd_en  output  1 each  memory write/read enables (drive WR_EN_DM/RD_EN_DM).
REQ-011 The block SHALL have ports mem_addr  output  ADDR_W,  mem_wdata  output  WORD_SIZE  memory address and write data.
REQ-012 The block SHALL have port mem_rdata  input  WORD_SIZE  memory read data, registered by memory one cycle after mem_rd_en.
REQ-013 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, RESP; all outputs SHALL be registered.
REQ-015 In IDLE with any req high, the block SHALL select a winner, latch its we/addr/wdata, and go to ISSUE next cycle.
REQ-016 In ISSUE, exactly one of mem_rd_en/mem_wr_en SHALL be high for exactly one cycle with mem_addr/mem_wdata from the latched request, and the winner's gnt SHALL pulse high that same cycle.
REQ-017 From ISSUE, a write SHALL return to IDLE; a read SHALL go to RESP.
REQ-018 In RESP, the winner's rvalid SHALL pulse for one cycle with its rdata equal to mem_rdata, then return to IDLE.
REQ-019 Latency from req sampled in IDLE: gnt at +1 cycle; rvalid at +2 cycles; minimum request spacing is 2 cycles (write) and 3 cycles (read).
REQ-020 Requesters SHALL hold req, we, addr, wdata stable until gnt; the block SHALL ignore changes after the winner is latched.
REQ-021 Arbitration SHALL be round-robin: a 1-bit last-grant pointer; when both req are high, the requester not granted last wins; single req always wins.
REQ-022 mem_wr_en and mem_rd_en SHALL never be high simultaneously; gnt SHALL never go to both requesters in one cycle.
REQ-023 rdata outputs SHALL hold their last value when rvalid is low; the non-winning requester's rdata SHALL not change.
REQ-024 A req dropped before selection in IDLE SHALL produce no memory access.
REQ-025 Requests arriving during ISSUE/RESP SHALL wait; they are evaluated in the next IDLE cycle.

Reset
REQ-026 RESET low SHALL immediately force state IDLE, pointer to favour CPU, all gnt/rvalid/mem enables/busy to 0, and mem_addr, mem_wdata, cpu_rdata, dma_rdata to 0.
REQ-027 RESET asserted mid-ISSUE or mid-RESP SHALL abort the transaction with no pending gnt/rvalid after release; first post-reset sample occurs in IDLE.

Verification
REQ-028 CPU write addr 0x005 data 0x7FFFF -> mem_wr_en, mem_addr=0x005, mem_wdata=0x7FFFF, cpu_gnt all high one cycle after req; back in IDLE next cycle.
REQ-029 DMA read addr 0x3FF with mem_rdata=0x12345 -> mem_rd_en +1 cycle, dma_rvalid +2 cycles with dma_rdata=0x12345; cpu_rdata unchanged.
REQ-030 Both req held high continuously after reset -> grants alternate CPU, DMA, CPU, DMA; no cycle with both gnt high.
REQ-031 Request raised while busy=1 -> no memory enable until IDLE, then served with gnt exactly one cycle after IDLE.
REQ-032 RESET pulsed low during RESP -> rvalid never asserted, all outputs 0 immediately, next CPU request served normally with CPU winning a simultaneous tie.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  dmem_arbiter_if : CPU/DMA request ports and data-memory port of dmem_arbiter
//  Revision 1.0
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int WORD_SIZE = 19,
    parameter int ADDR_W    = 10
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [WORD_SIZE-1:0] cpu_wdata;
    logic                 cpu_gnt;
    logic                 cpu_rvalid;
    logic [WORD_SIZE-1:0] cpu_rdata;

    logic                 dma_req;
    logic                 dma_we;
    logic [ADDR_W-1:0]    dma_addr;
    logic [WORD_SIZE-1:0] dma_wdata;
    logic                 dma_gnt;
    logic                 dma_rvalid;
    logic [WORD_SIZE-1:0] dma_rdata;

    logic                 mem_wr_en;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    logic                 busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  dmem_arbiter : round-robin CPU/DMA arbiter in front of a single-port DMEM
//  Revision 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int WORD_SIZE = 19,
    parameter int ADDR_W    = 10
) (
    input  wire logic      CLK,
    input  wire logic      RESET,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state_q,      state_d;
    logic                 last_dma_q,   last_dma_d;
    logic                 win_dma_q,    win_dma_d;
    logic                 we_q,         we_d;
    logic [ADDR_W-1:0]    mem_addr_q,   mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q,  mem_wdata_d;
    logic                 mem_wr_en_q,  mem_wr_en_d;
    logic                 mem_rd_en_q,  mem_rd_en_d;
    logic                 cpu_gnt_q,    cpu_gnt_d;
    logic                 dma_gnt_q,    dma_gnt_d;
    logic                 cpu_rvalid_q, cpu_rvalid_d;
    logic                 dma_rvalid_q, dma_rvalid_d;
    logic [WORD_SIZE-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [WORD_SIZE-1:0] dma_rdata_q,  dma_rdata_d;
    logic                 busy_q,       busy_d;

    logic                 pick_dma;
    logic                 sel_we;

    // On a tie the requester that was not served last wins.
    assign pick_dma = bus.dma_req & (~bus.cpu_req | ~last_dma_q);
    assign sel_we   = pick_dma ? bus.dma_we : bus.cpu_we;

    always_comb begin
        state_d      = state_q;
        last_dma_d   = last_dma_q;
        win_dma_d    = win_dma_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_en_d  = 1'b0;
        mem_rd_en_d  = 1'b0;
        cpu_gnt_d    = 1'b0;
        dma_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dma_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    state_d     = ISSUE;
                    win_dma_d   = pick_dma;
                    last_dma_d  = pick_dma;
                    we_d        = sel_we;
                    mem_addr_d  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
                    mem_wdata_d = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
                    mem_wr_en_d = sel_we;
                    mem_rd_en_d = ~sel_we;
                    cpu_gnt_d   = ~pick_dma;
                    dma_gnt_d   = pick_dma;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d      = RESP;
                    cpu_rvalid_d = ~win_dma_q;
                    dma_rvalid_d = win_dma_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (win_dma_q) begin
                    dma_rdata_d = bus.mem_rdata;
                end else begin
                    cpu_rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            last_dma_q   <= 1'b1;
            win_dma_q    <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_en_q  <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_dma_q   <= last_dma_d;
            win_dma_q    <= win_dma_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_rd_en_q  <= mem_rd_en_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dma_gnt    = dma_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;

    // Memory data lands in the RESP cycle itself, so it is forwarded while
    // rvalid is high and captured at the end of RESP to be held afterwards.
    assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dma_rdata  = dma_rvalid_q ? bus.mem_rdata : dma_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  tb_dmem_arbiter : directed and randomized checks of dmem_arbiter
//  Revision 1.0
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int W     = 19;
    localparam int A     = 10;
    localparam int NRAND = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.WORD_SIZE(W), .ADDR_W(A)) bus ();

    dmem_arbiter #(.WORD_SIZE(W), .ADDR_W(A)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    // Synchronous data memory: one-cycle registered read, reloaded on reset.
    logic [W-1:0] mem [0:(1<<A)-1];

    function automatic logic [W-1:0] pat(input int i);
        if (i == 1023) return 19'h12345;
        return W'(i * 2731 + 77);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << A); i++) mem[i] <= pat(i);
            bus.mem_rdata <= '0;
        end else begin
            if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_wr_en, mem_rd_en, busy}
    function automatic logic [6:0] flags();
        return {bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid,
                bus.mem_wr_en, bus.mem_rd_en, bus.busy};
    endfunction

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (flags() !== 7'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", flags(), 7'b0); end
        n_cmp++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        n_cmp++; if (bus.cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
        n_cmp++; if (bus.dma_rdata !== '0) begin n_fail++; $display("FAIL reset_dma_rdata: got %h expected 0", bus.dma_rdata); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (flags() !== 7'b0) begin n_fail++; $display("FAIL reset_hold_flags: got %b expected %b", flags(), 7'b0); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0) begin n_fail++; $display("FAIL reset_idle_flags: got %b expected %b", flags(), 7'b0); end
    endtask

    task automatic test_cpu_write();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h005; bus.cpu_wdata = 19'h7FFFF;
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b1000101) begin n_fail++; $display("FAIL cpu_write_issue: got %b expected %b", flags(), 7'b1000101); end
        n_cmp++; if (bus.mem_addr !== 10'h005) begin n_fail++; $display("FAIL cpu_write_addr: got %h expected 005", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 19'h7FFFF) begin n_fail++; $display("FAIL cpu_write_wdata: got %h expected 7ffff", bus.mem_wdata); end
        drive_idle();
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0) begin n_fail++; $display("FAIL cpu_write_idle: got %b expected %b", flags(), 7'b0); end
        n_cmp++; if (mem[5] !== 19'h7FFFF) begin n_fail++; $display("FAIL cpu_write_mem: got %h expected 7ffff", mem[5]); end
    endtask

    task automatic test_dma_read();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 10'h3FF;
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0100011) begin n_fail++; $display("FAIL dma_read_issue: got %b expected %b", flags(), 7'b0100011); end
        n_cmp++; if (bus.mem_addr !== 10'h3FF) begin n_fail++; $display("FAIL dma_read_addr: got %h expected 3ff", bus.mem_addr); end
        drive_idle();
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0001001) begin n_fail++; $display("FAIL dma_read_resp: got %b expected %b", flags(), 7'b0001001); end
        n_cmp++; if (bus.dma_rdata !== 19'h12345) begin n_fail++; $display("FAIL dma_read_data: got %h expected 12345", bus.dma_rdata); end
        n_cmp++; if (bus.cpu_rdata !== '0) begin n_fail++; $display("FAIL dma_read_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0) begin n_fail++; $display("FAIL dma_read_idle: got %b expected %b", flags(), 7'b0); end
        n_cmp++; if (bus.dma_rdata !== 19'h12345) begin n_fail++; $display("FAIL dma_read_hold: got %h expected 12345", bus.dma_rdata); end
    endtask

    task automatic test_round_robin();
        bit exp_dma = 1'b0;
        int ngnt    = 0;
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h001; bus.cpu_wdata = 19'h00001;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 10'h002;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.cpu_gnt && bus.dma_gnt) begin
                n_cmp++; n_fail++;
                $display("FAIL rr_double_gnt: got both grants at cycle %0d expected one", c);
            end else if (bus.cpu_gnt || bus.dma_gnt) begin
                n_cmp++;
                if (bus.dma_gnt !== exp_dma) begin
                    n_fail++;
                    $display("FAIL rr_order: got dma_gnt=%b expected %b (grant %0d)", bus.dma_gnt, exp_dma, ngnt);
                end
                exp_dma = ~exp_dma;
                ngnt++;
            end
        end
        n_cmp++; if (ngnt != 6) begin n_fail++; $display("FAIL rr_count: got %0d expected 6", ngnt); end
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_busy_wait();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h007;
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b1000011) begin n_fail++; $display("FAIL busy_cpu_issue: got %b expected %b", flags(), 7'b1000011); end
        drive_idle();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'h009; bus.dma_wdata = 19'h00155;
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0010001) begin n_fail++; $display("FAIL busy_wait_resp: got %b expected %b", flags(), 7'b0010001); end
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0) begin n_fail++; $display("FAIL busy_wait_idle: got %b expected %b", flags(), 7'b0); end
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0100101) begin n_fail++; $display("FAIL busy_dma_served: got %b expected %b", flags(), 7'b0100101); end
        n_cmp++; if (bus.mem_addr !== 10'h009) begin n_fail++; $display("FAIL busy_dma_addr: got %h expected 009", bus.mem_addr); end
        drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_resp();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h3FF;
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b1000011) begin n_fail++; $display("FAIL rst_mid_issue: got %b expected %b", flags(), 7'b1000011); end
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (flags() !== 7'b0) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected %b", flags(), 7'b0); end
        n_cmp++; if (bus.cpu_rdata !== '0) begin n_fail++; $display("FAIL rst_mid_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
        n_cmp++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL rst_mid_mem_addr: got %h expected 0", bus.mem_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (flags() !== 7'b0) begin n_fail++; $display("FAIL rst_mid_after: got %b expected %b (cycle %0d)", flags(), 7'b0, c); end
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h010; bus.cpu_wdata = 19'h00AAA;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'h011; bus.dma_wdata = 19'h00BBB;
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b1000101) begin n_fail++; $display("FAIL rst_tie_cpu_wins: got %b expected %b", flags(), 7'b1000101); end
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (flags() !== 7'b0100101) begin n_fail++; $display("FAIL rst_tie_dma_next: got %b expected %b", flags(), 7'b0100101); end
        drive_idle();
        @(posedge clk); #1;
    endtask

    // Transaction-level reference: each accepted request books its grant,
    // memory strobe and optional read response into per-cycle tables.
    bit           e_cg   [0:NRAND+3];
    bit           e_dg   [0:NRAND+3];
    bit           e_cv   [0:NRAND+3];
    bit           e_dv   [0:NRAND+3];
    bit           e_wr   [0:NRAND+3];
    bit           e_rd   [0:NRAND+3];
    bit           e_busy [0:NRAND+3];
    logic [A-1:0] e_addr [0:NRAND+3];
    logic [W-1:0] e_wdat [0:NRAND+3];
    logic [W-1:0] e_rdv  [0:NRAND+3];
    logic [W-1:0] refmem [0:(1<<A)-1];

    task automatic test_random();
        bit           cp = 0, dp = 0, cwe = 0, dwe = 0, last_dma = 1, wd, we;
        logic [A-1:0] ca = '0, da = '0, ad;
        logic [W-1:0] cw = '0, dw = '0, dt;
        logic [W-1:0] exp_cr = '0, exp_dr = '0;
        logic [6:0]   ef;
        int           free_at = 1;
        for (int i = 0; i < NRAND + 4; i++) begin
            e_cg[i] = 0; e_dg[i] = 0; e_cv[i] = 0; e_dv[i] = 0;
            e_wr[i] = 0; e_rd[i] = 0; e_busy[i] = 0;
            e_addr[i] = '0; e_wdat[i] = '0; e_rdv[i] = '0;
        end
        for (int i = 0; i < (1 << A); i++) refmem[i] = pat(i);
        do_reset();
        for (int n = 1; n <= NRAND; n++) begin
            if (!cp && $urandom_range(0, 2) == 0) begin
                cp = 1; cwe = 1'($urandom_range(0, 1)); ca = A'($urandom_range(0, 15)); cw = W'($urandom);
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; dwe = 1'($urandom_range(0, 1)); da = A'($urandom_range(0, 15)); dw = W'($urandom);
            end
            bus.cpu_req = cp; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cw;
            bus.dma_req = dp; bus.dma_we = dwe; bus.dma_addr = da; bus.dma_wdata = dw;
            if (n >= free_at && (cp || dp)) begin
                wd = dp && (!cp || !last_dma);
                last_dma = wd;
                we = wd ? dwe : cwe;
                ad = wd ? da : ca;
                dt = wd ? dw : cw;
                e_cg[n] = !wd; e_dg[n] = wd; e_wr[n] = we; e_rd[n] = !we;
                e_addr[n] = ad; e_wdat[n] = dt; e_busy[n] = 1;
                if (we) begin
                    refmem[ad] = dt;
                    free_at = n + 2;
                end else begin
                    e_cv[n+1] = !wd; e_dv[n+1] = wd; e_rdv[n+1] = refmem[ad];
                    e_busy[n+1] = 1;
                    free_at = n + 3;
                end
            end
            @(posedge clk); #1;
            if (e_cv[n]) exp_cr = e_rdv[n];
            if (e_dv[n]) exp_dr = e_rdv[n];
            ef = {e_cg[n], e_dg[n], e_cv[n], e_dv[n], e_wr[n], e_rd[n], e_busy[n]};
            n_cmp++; if (flags() !== ef) begin n_fail++; $display("FAIL rand_flags: got %b expected %b at cycle %0d", flags(), ef, n); end
            if (e_wr[n] || e_rd[n]) begin
                n_cmp++; if (bus.mem_addr !== e_addr[n]) begin n_fail++; $display("FAIL rand_addr: got %h expected %h at cycle %0d", bus.mem_addr, e_addr[n], n); end
            end
            if (e_wr[n]) begin
                n_cmp++; if (bus.mem_wdata !== e_wdat[n]) begin n_fail++; $display("FAIL rand_wdata: got %h expected %h at cycle %0d", bus.mem_wdata, e_wdat[n], n); end
            end
            n_cmp++; if (bus.cpu_rdata !== exp_cr) begin n_fail++; $display("FAIL rand_cpu_rdata: got %h expected %h at cycle %0d", bus.cpu_rdata, exp_cr, n); end
            n_cmp++; if (bus.dma_rdata !== exp_dr) begin n_fail++; $display("FAIL rand_dma_rdata: got %h expected %h at cycle %0d", bus.dma_rdata, exp_dr, n); end
            if (e_cg[n]) cp = 0;
            if (e_dg[n]) dp = 0;
        end
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_dma_read();
        test_round_robin();
        test_busy_wait();
        test_reset_mid_resp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
